// File: rtl/timer_pkg.sv
// timer_pkg: shared types and constants for the countdown_timer block.
//   state_t          - controller states {IDLE, COUNT, EXPIRED}
//   DIG_MAX_ONES/TENS - wrap values for ones-type and tens-type BCD digits
//   TICK_DIV_DEFAULT - 50 MHz / 100 Hz prescale ratio
//   clamp_digit()    - saturates a preset BCD digit to its legal maximum
package timer_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED} state_t;

  localparam int DIG_MAX_ONES     = 9;
  localparam int DIG_MAX_TENS     = 5;
  localparam int TICK_DIV_DEFAULT = 500_000;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one 4-bit BCD down-counting digit of the borrow chain.
//   Clock, Resetn - clock, synchronous active-low reset
//   Load, D       - parallel load (wins over En)
//   En            - borrow-in: decrement this cycle
//   Q             - current digit value
//   Borrow        - borrow-out to the next digit (Q==0 while En)
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter int MAX = DIG_MAX_ONES
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [3:0] D,
  input  logic       En,
  output logic [3:0] Q,
  output logic       Borrow
);

  always_ff @(posedge Clock) begin
    if (!Resetn)   Q <= '0;
    else if (Load) Q <= D;
    else if (En)   Q <= (Q == 4'd0) ? 4'(MAX) : Q - 4'd1;
  end

  assign Borrow = En && (Q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS:cc BCD countdown at 100 Hz with expiry flag.
//   Clock, Resetn   - system clock, synchronous active-low reset
//   Load            - load sanitised preset D_min:D_sec, clear centis/decis,
//                     prescaler and Done; returns to IDLE
//   D_min, D_sec    - BCD preset (tens in [7:4], ones in [3:0])
//   Run             - level: 1 count, 0 pause
//   Q_*             - six BCD output digits
//   Tick            - one-cycle pulse on each 100 Hz decrement
//   Done            - expiry flag (level in EXPIRED; one-cycle pulse per
//                     expiry when COUNTDOWN_AUTO_RELOAD_EN is defined)
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (reload preset on expiry).
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int TICK_W   = 19
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [7:0] D_min,
  input  logic [7:0] D_sec,
  input  logic       Run,
  output logic [3:0] Q_centis,
  output logic [3:0] Q_decis,
  output logic [3:0] Q_secs,
  output logic [3:0] Q_decas,
  output logic [3:0] Q_mins,
  output logic [3:0] Q_deca_mins,
  output logic       Tick,
  output logic       Done
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0] MAX_ONES = 4'(DIG_MAX_ONES);
  localparam logic [3:0] MAX_TENS = 4'(DIG_MAX_TENS);

  state_t            state, state_n;
  logic [TICK_W-1:0] presc, presc_n;
  logic              done_n;
  logic [5:0][3:0]   q, preset, dig_d;
  logic [5:0]        en, borrow;
  logic              dig_load, tick, expire, reload;

  // digit index: 0 centis, 1 decis, 2 secs, 3 decas, 4 mins, 5 deca_mins
  assign preset = {clamp_digit(D_min[7:4], MAX_TENS), clamp_digit(D_min[3:0], MAX_ONES),
                   clamp_digit(D_sec[7:4], MAX_TENS), clamp_digit(D_sec[3:0], MAX_ONES),
                   4'd0, 4'd0};

  assign tick   = (state == COUNT) && Run && (presc == TICK_LAST);
  // 00:00.01 about to decrement: the chain lands on zero this edge
  assign expire = tick && (q == 24'h000001);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [5:0][3:0] shadow;

  always_ff @(posedge Clock) begin
    if (!Resetn)   shadow <= '0;
    else if (Load) shadow <= preset;
  end

  // a zero shadow cannot restart, so that case falls through to EXPIRED
  assign reload   = expire && !Load && (|shadow);
  assign dig_load = Load || reload;
  assign dig_d    = Load ? preset : shadow;
`else
  assign reload   = 1'b0;
  assign dig_load = Load;
  assign dig_d    = preset;
`endif

  assign en[0] = tick && !Load;

  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_down_digit #(
      .MAX((i == 3 || i == 5) ? DIG_MAX_TENS : DIG_MAX_ONES)
    ) u_dig (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Load   (dig_load),
      .D      (dig_d[i]),
      .En     (en[i]),
      .Q      (q[i]),
      .Borrow (borrow[i])
    );
    if (i > 0) begin : g_chain
      assign en[i] = borrow[i-1];
    end
  end

  // expiry stops the chain at zero, so the top digit never borrows
  logic unused_borrow;
  assign unused_borrow = borrow[5];

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      presc <= '0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      Done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    done_n  = 1'b0;
    if (Load) begin
      state_n = IDLE;
      presc_n = '0;
    end else begin
      unique case (state)
        IDLE: if (Run && (|q)) state_n = COUNT;
        COUNT: begin
          if (!Run) state_n = IDLE;
          else begin
            presc_n = tick ? '0 : presc + 1'b1;
            if (expire) begin
              done_n = 1'b1;
              if (!reload) state_n = EXPIRED;
            end
          end
        end
        EXPIRED: done_n = 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  assign Tick        = tick;
  assign Q_centis    = q[0];
  assign Q_decis     = q[1];
  assign Q_secs      = q[2];
  assign Q_decas     = q[3];
  assign Q_mins      = q[4];
  assign Q_deca_mins = q[5];

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench for countdown_timer with TICK_DIV=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_countdown_timer;
  logic       Clock, Resetn, Load, Run;
  logic [7:0] D_min, D_sec;
  logic [3:0] Q_centis, Q_decis, Q_secs, Q_decas, Q_mins, Q_deca_mins;
  logic       Tick, Done;
  int         n_cmp = 0;
  int         n_err = 0;

  countdown_timer #(.TICK_DIV(4), .TICK_W(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .Load(Load), .D_min(D_min), .D_sec(D_sec),
    .Run(Run), .Q_centis(Q_centis), .Q_decis(Q_decis), .Q_secs(Q_secs),
    .Q_decas(Q_decas), .Q_mins(Q_mins), .Q_deca_mins(Q_deca_mins),
    .Tick(Tick), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  function automatic logic [23:0] dig();
    return {Q_deca_mins, Q_mins, Q_decas, Q_secs, Q_decis, Q_centis};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] m, input logic [7:0] s);
    Load = 1'b1; D_min = m; D_sec = s;
    cyc(1);
    Load = 1'b0;
  endtask

  initial begin
    // reset overrides Load and Run
    Resetn = 1'b0; Load = 1'b1; Run = 1'b1; D_min = 8'h12; D_sec = 8'h34;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rst_tick", 24'(Tick), 24'h0);
    end
    chk("rst_digits", dig(), 24'h000000);
    chk("rst_done", 24'(Done), 24'h0);

    // all-zero digits: Run ignored
    Resetn = 1'b1; Load = 1'b0;
    cyc(5);
    chk("zero_idle_digits", dig(), 24'h000000);
    chk("zero_idle_tick", 24'(Tick), 24'h0);
    chk("zero_idle_done", 24'(Done), 24'h0);

    // 01:00 preset, first tick TICK_DIV cycles after entering COUNT
    load(8'h01, 8'h00);
    chk("load_0100", dig(), 24'h010000);
    cyc(3);
    chk("tick_early", 24'(Tick), 24'h0);
    cyc(1);
    chk("tick_first", 24'(Tick), 24'h1);
    chk("pre_dec_digits", dig(), 24'h010000);
    cyc(1);
    chk("first_dec", dig(), 24'h005999);
    chk("tick_after", 24'(Tick), 24'h0);
    cyc(400);
    chk("100_ticks", dig(), 24'h005899);
    cyc(5448);
    chk("reach_4537", dig(), 24'h004537);

    // pause with prescaler mid-count (2 of 4)
    cyc(2);
    Run = 1'b0;
    cyc(20);
    chk("pause_digits", dig(), 24'h004537);
    chk("pause_tick", 24'(Tick), 24'h0);
    Run = 1'b1;
    cyc(1);
    chk("resume_tick0", 24'(Tick), 24'h0);
    cyc(1);
    chk("resume_tick1", 24'(Tick), 24'h1);
    cyc(1);
    chk("resume_dec", dig(), 24'h004536);

    // clamp on load, Load clears centis
    Run = 1'b0;
    load(8'hFA, 8'h7C);
    chk("clamp_load", dig(), 24'h595900);
    chk("clamp_done", 24'(Done), 24'h0);
    Run = 1'b1;
    cyc(4);
    chk("tick_before_load", 24'(Tick), 24'h1);
    // Load lands on the tick edge: preset wins
    load(8'h02, 8'h30);
    chk("load_on_tick", dig(), 24'h023000);
    cyc(3);
    chk("presc_cleared", 24'(Tick), 24'h0);
    cyc(1);
    chk("tick_after_reload", 24'(Tick), 24'h1);
    cyc(1);
    chk("borrow_0230", dig(), 24'h022999);

    load(8'h10, 8'h00);
    cyc(5);
    chk("borrow_1000", dig(), 24'h095999);

    // expiry from 00:01.00
    load(8'h00, 8'h01);
    chk("load_0001", dig(), 24'h000100);
    cyc(400);
    chk("last_digits", dig(), 24'h000001);
    chk("last_tick", 24'(Tick), 24'h1);
    chk("last_done", 24'(Done), 24'h0);
    cyc(1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("reload_digits", dig(), 24'h000100);
    chk("reload_done", 24'(Done), 24'h1);
    cyc(1);
    chk("reload_done_pulse", 24'(Done), 24'h0);
    cyc(398);
    chk("reload2_last", dig(), 24'h000001);
    chk("reload2_done_low", 24'(Done), 24'h0);
    cyc(1);
    chk("reload2_digits", dig(), 24'h000100);
    chk("reload2_done", 24'(Done), 24'h1);
    cyc(1);
    chk("reload2_pulse", 24'(Done), 24'h0);
`else
    chk("expire_digits", dig(), 24'h000000);
    chk("expire_done", 24'(Done), 24'h1);
    chk("expire_tick", 24'(Tick), 24'h0);
    cyc(20);
    chk("expired_hold", dig(), 24'h000000);
    chk("expired_done", 24'(Done), 24'h1);
    Run = 1'b0;
    cyc(3);
    Run = 1'b1;
    cyc(5);
    chk("expired_run_tgl", dig(), 24'h000000);
    chk("expired_run_done", 24'(Done), 24'h1);
    chk("expired_tick", 24'(Tick), 24'h0);
`endif

    // Load clears Done; zero preset stays idle
    load(8'h00, 8'h00);
    chk("load_clears_done", 24'(Done), 24'h0);
    cyc(3);
    chk("zero_load_done", 24'(Done), 24'h0);
    chk("zero_load_digits", dig(), 24'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting counterpart of the MM:SS:cc stopwatch chain: loads a minutes:seconds preset in BCD, then counts down at 100 Hz to 00:00.00 and flags expiry.
- Outputs six BCD digits (centis, decis, secs, decas, mins, deca_mins) that feed the existing per-digit 7-segment decoders unchanged.
- Single clock domain; the 100 Hz tick comes from an internal prescaler, not a derived clock.

Parameters:
- TICK_DIV, 500_000, Clock cycles per 100 Hz tick (50 MHz / 100).
- TICK_W, 19, prescaler width; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
- Clock  in  1  system clock (50 MHz on board).
- Resetn  in  1  synchronous, active-low reset.
- Load  in  1  active-high; loads the preset and clears centis, decis and the prescaler.
- D_min  in  8  preset minutes, BCD: [7:4] tens, [3:0] ones.
- D_sec  in  8  preset seconds, BCD: [7:4] tens, [3:0] ones.
- Run  in  1  level; 1 = count, 0 = hold (pause).
- Q_centis, Q_decis, Q_secs, Q_decas, Q_mins, Q_deca_mins  out  4 each  current BCD digits.
- Tick  out  1  one-cycle pulse on every 100 Hz decrement.
- Done  out  1  expiry flag.

Behaviour:
- Reset (Resetn=0 at a rising edge): all digits 0, prescaler 0, Tick=0, Done=0, state IDLE. Reset overrides Load and Run.
- Preset sanitising on Load:
  - Tens digits > 5 clamp to 5.
  - Ones digits > 9 clamp to 9.
  - Example: D_sec=8'h7C loads 59.
- Priority, highest first: Resetn, Load, Run.
- Load latency: digits show the preset after the same edge that samples Load=1. Load from any state goes to IDLE, clears Done and prescaler, and aborts a countdown in progress.
- States:
  - IDLE -> COUNT when Run=1 and digits are non-zero.
  - With digits all zero, Run is ignored and the block stays in IDLE with Done=0.
  - COUNT -> IDLE when Run=0: digits and prescaler hold, so this is the pause.
  - COUNT -> EXPIRED on the tick edge where digits go 00:00.01 -> 00:00.00.
  - EXPIRED holds all digits at 0 and ignores Run. Only Load or reset leaves it.
- Prescaler:
  - Increments only in COUNT with Run=1.
  - At TICK_DIV-1 it wraps to 0 and Tick pulses for exactly that cycle.
  - The digit decrement happens on that same edge.
  - The first tick occurs TICK_DIV cycles after entering COUNT from a fresh Load.
- Borrow chain, decremented once per tick:
  - A digit at 0 wraps to its max and borrows from the next digit up.
  - Max per digit: centis 9, decis 9, secs 9, decas 5, mins 9, deca_mins 5.
  - Example: 10:00.00 -> 09:59.99.
  - No wrap below 00:00.00; the expiry transition prevents it.
- Done:
  - Registered; asserts on the same edge the digits reach zero.
  - Stays high while in EXPIRED.
  - Deasserts on Load or reset.
- Simultaneous Load and tick: Load wins and no decrement is applied.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- With the macro defined:
  - The sanitised preset is stored in a shadow register at Load.
  - On expiry the digits reload from the shadow on the same edge and the block stays in COUNT if Run=1.
  - Done is a one-cycle pulse per expiry. EXPIRED is never entered unless the shadow is zero.
- Without the macro: behaviour exactly as above. No shadow register is synthesised.

Decomposition:
- Package timer_pkg:
  - State enum {IDLE, COUNT, EXPIRED}.
  - Digit max constants: DIG_MAX_ONES=9, DIG_MAX_TENS=5.
  - Default TICK_DIV.
- Sub-module bcd_down_digit, instantiated six times. It is one 4-bit digit with parameter MAX and ports Clock, Resetn, Load, D, En (borrow in), Q, Borrow (Q==0 & En).

Test Plan (TICK_DIV=4 in simulation):
- Reset with Run=1, Load=1 -> all digits 0, Done=0, Tick never pulses.
- Load D_min=8'h01, D_sec=8'h00, Run=1 -> after 4 cycles Tick=1 and digits 00:59.99; after 100 ticks digits 00:58.99.
- Load 00:00, set centis path via Load 8'h00/8'h01, run to 00:00.00 -> Done=1 on the zero edge; further ticks keep 00:00.00; Run toggling has no effect until Load clears Done.
- Run=0 for 20 cycles mid-count at 00:45.37 -> digits and prescaler frozen; Run=1 resumes with the remaining prescaler count.
- Load D_min=8'hFA, D_sec=8'h7C -> loads 59:59.00. Load asserted on a Tick cycle -> preset wins, no decrement.
- COUNTDOWN_AUTO_RELOAD_EN build, preset 00:01 -> Done pulses for one cycle every 100 ticks and digits reload to 00:01.00.
